// File: rtl/disp_msg_sched_pkg.sv
// Shared display-path definitions: blank codes, requester count, scheduler state encoding.
// Every block that drives or renders the character line imports this package.
package disp_msg_sched_pkg;

    localparam int          NREQ       = 3;
    localparam int          CNT_W      = 27;
    localparam int          LINE_W     = 36;
    localparam logic [5:0]  BLANK_CHAR = 6'b111110;
    localparam logic [35:0] BLANK_LINE = {6{BLANK_CHAR}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } sched_state_t;

    function automatic logic [NREQ-1:0] onehot3(input logic [1:0] idx);
        onehot3 = 3'b001 << idx;
    endfunction

endpackage

// File: rtl/disp_msg_sched_rr_arb3.sv
// Three-way round-robin winner select: the search starts one above the last grant and wraps.
module rr_arb3
    import disp_msg_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      win,
    output logic            any
);

    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;

    always_comb begin
        case (last)
            2'd0: begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1: begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
    end

    always_comb begin
        any = |req;
        win = 2'd0;
        if (req[p0])
            win = p0;
        else if (req[p1])
            win = p1;
        else if (req[p2])
            win = p2;
    end

endmodule

// File: rtl/disp_msg_sched.sv
// Display message scheduler: grants one requester's 6-character line at a time and
// keeps it on the display for HOLD_CYCLES cycles before the next grant.
//
//  state | meaning
//  IDLE  | nothing in a hold window; any request is granted at the next edge
//  HOLD  | line on display, cnt counts down; at cnt==0 regrant or fall back to IDLE
module disp_msg_sched
    import disp_msg_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [LINE_W-1:0] msg0,
    input  logic [LINE_W-1:0] msg1,
    input  logic [LINE_W-1:0] msg2,
    input  logic              clr,
    output logic [NREQ-1:0]   gnt,
    output logic [LINE_W-1:0] data_out,
    output logic              busy
);

    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

    sched_state_t      state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        last;
    logic [1:0]        win;
    logic              any;
    logic [LINE_W-1:0] msg_sel;
    logic              grant_now;

    rr_arb3 u_arb (
        .req  (req),
        .last (last),
        .win  (win),
        .any  (any)
    );

    always_comb begin
        case (win)
            2'd0:    msg_sel = msg0;
            2'd1:    msg_sel = msg1;
            default: msg_sel = msg2;
        endcase
    end

    // A grant is possible from IDLE, or from HOLD once the window has run out.
    assign grant_now = any && ((state == ST_IDLE) || (cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            last     <= 2'd2;
            data_out <= BLANK_LINE;
            gnt      <= '0;
            busy     <= 1'b0;
        end else begin
            gnt <= '0;
            if (clr) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                data_out <= BLANK_LINE;
                busy     <= 1'b0;
            end else if (grant_now) begin
                state    <= ST_HOLD;
                cnt      <= HOLD_M1;
                last     <= win;
                data_out <= msg_sel;
                gnt      <= onehot3(win);
                busy     <= 1'b1;
            end else begin
                case (state)
                    ST_HOLD: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_disp_msg_sched.sv
// Bench for disp_msg_sched with HOLD_CYCLES=4: directed scenarios followed by random
// requests/messages/clears, all checked against a slot-timing reference model.
module tb_disp_msg_sched;

    localparam int          HOLD  = 4;
    localparam logic [35:0] BLANK = 36'hFBEFBEFBE;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = '0;
    logic [35:0] msg0 = '0;
    logic [35:0] msg1 = '0;
    logic [35:0] msg2 = '0;
    logic        clr = 1'b0;
    logic [2:0]  gnt;
    logic [35:0] data_out;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    // Reference model: a grant may happen at any edge at or after next_ok.
    int          ecount  = 0;
    int          next_ok = 0;
    int          m_last  = 2;
    logic [35:0] m_data  = BLANK;
    logic [2:0]  m_gnt   = '0;
    logic        m_busy  = 1'b0;

    disp_msg_sched #(.HOLD_CYCLES(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .msg0     (msg0),
        .msg1     (msg1),
        .msg2     (msg2),
        .clr      (clr),
        .gnt      (gnt),
        .data_out (data_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        next_ok = 0;
        m_last  = 2;
        m_data  = BLANK;
        m_gnt   = '0;
        m_busy  = 1'b0;
    endtask

    task automatic model_edge();
        int w;
        w = -1;
        m_gnt = '0;
        if (clr) begin
            m_data  = BLANK;
            m_busy  = 1'b0;
            next_ok = 0;
        end else if (ecount >= next_ok) begin
            for (int k = 1; k <= 3; k++) begin
                if (w < 0 && req[(m_last + k) % 3]) w = (m_last + k) % 3;
            end
            if (w >= 0) begin
                m_data  = (w == 0) ? msg0 : (w == 1) ? msg1 : msg2;
                m_gnt   = 3'b001 << w;
                m_last  = w;
                m_busy  = 1'b1;
                next_ok = ecount + HOLD;
            end else begin
                m_busy = 1'b0;
            end
        end
        ecount++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("data_out", data_out, m_data);
        chk("gnt", {33'd0, gnt}, {33'd0, m_gnt});
        chk("busy", {35'd0, busy}, {35'd0, m_busy});
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_data", data_out, BLANK);
        chk("rst_gnt", {33'd0, gnt}, 36'd0);
        chk("rst_busy", {35'd0, busy}, 36'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset before any clock edge
        rst = 1'b1;
        #1;
        chk("rst0_data", data_out, BLANK);
        chk("rst0_gnt", {33'd0, gnt}, 36'd0);
        chk("rst0_busy", {35'd0, busy}, 36'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single grant to requester 1, then the line is retained after the hold
        req  = 3'b010;
        msg1 = 36'h123456789;
        tick();
        chk("g1_gnt", {33'd0, gnt}, 36'h2);
        chk("g1_data", data_out, 36'h123456789);
        req = 3'b000;
        for (int i = 2; i <= 7; i++) begin
            tick();
            chk("g1_busy", {35'd0, busy}, (i <= 4) ? 36'd1 : 36'd0);
            chk("g1_keep", data_out, 36'h123456789);
        end

        // All three requesting: rotation 0,1,2,0 with msg0 changed mid-hold
        do_reset();
        msg0 = 36'hAAAAAAAAA;
        msg1 = 36'hBBBBBBBBB;
        msg2 = 36'hCCCCCCCCC;
        req  = 3'b111;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 2) msg0 = 36'hDDDDDDDDD;
            if (c == 3) chk("hold_msg0", data_out, 36'hAAAAAAAAA);
            if (c == 13) begin
                chk("rr_gnt13", {33'd0, gnt}, 36'h1);
                chk("rr_data13", data_out, 36'hDDDDDDDDD);
            end
        end
        req = 3'b000;

        // Clear during a hold with requester 2 pending
        do_reset();
        req = 3'b001;
        tick();
        req = 3'b100;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_blank", data_out, BLANK);
        tick();
        chk("clr_gnt", {33'd0, gnt}, 36'h4);
        req = 3'b000;

        // Async reset in the middle of a hold
        do_reset();
        req = 3'b001;
        tick();
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_data", data_out, BLANK);
        chk("mid_rst_busy", {35'd0, busy}, 36'd0);
        chk("mid_rst_gnt", {33'd0, gnt}, 36'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_gnt", {33'd0, gnt}, 36'h1);

        // Random traffic including dropped requests and occasional clears
        for (int i = 0; i < 400; i++) begin
            req  = 3'($urandom_range(0, 7));
            msg0 = {4'($urandom), 32'($urandom)};
            msg1 = {4'($urandom), 32'($urandom)};
            msg2 = {4'($urandom), 32'($urandom)};
            clr  = ($urandom_range(0, 15) == 0);
            tick();
            #2;
        end
        clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/disp_msg_sched.md
DISP_MSG_SCHED -- requirements
Module: disp_msg_sched

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 100000000, minimum cycles a granted message stays on the display (legal range 1..2^27-1).
REQ-002 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req  in  3  per-requester display request, level, bit k = requester k.
REQ-005 SHALL have ports msg0/msg1/msg2  in  36 each  six 6-bit character codes from requester k, char 5 in [35:30] down to char 0 in [5:0].
REQ-006 SHALL have port clr  in  1  synchronous display clear, one-cycle pulse.
REQ-007 SHALL have port gnt  out  3  one-hot, one-cycle acknowledge that msgk was latched.
REQ-008 SHALL have port data_out  out  36  registered character line to the display renderer.
REQ-009 SHALL have port busy  out  1  high while a message is inside its hold window.

Function
REQ-010 SHALL implement FSM states IDLE and HOLD, plus registers data_out, 27-bit down-counter cnt, 2-bit last-grant pointer last.
REQ-011 SHALL choose the winner round-robin: search req from index last+1 upward mod 3; first set bit wins.
REQ-012 In IDLE with any req bit set at an edge, SHALL at that edge: latch msg[win] into data_out, pulse gnt[win] for the next cycle, set last=win, set cnt=HOLD_CYCLES-1, enter HOLD.
REQ-013 In HOLD with cnt!=0, SHALL decrement cnt, hold data_out, ignore req and msg changes.
REQ-014 In HOLD with cnt==0 and any req set, SHALL grant per REQ-012 at that edge, with no IDLE bubble, so each message is displayed exactly HOLD_CYCLES cycles.
REQ-015 In HOLD with cnt==0 and req==0, SHALL enter IDLE while keeping data_out unchanged.
REQ-016 busy SHALL equal (state==HOLD); gnt SHALL be zero except the cycle after a grant edge.
REQ-017 clr SHALL take priority over every other event: at that edge, data_out=blank line, state=IDLE, cnt=0, no gnt, last unchanged; pending req is served at the following edge.
REQ-018 With HOLD_CYCLES=1, SHALL allow a grant every cycle while requests persist.
REQ-019 A requester whose req drops before its turn SHALL NOT be granted; msg values are sampled only at the grant edge.

Reset
REQ-020 On rst, SHALL asynchronously set data_out=36'hFBEFBEFBE (six blank codes 6'b111110), gnt=0, busy=0, state=IDLE, cnt=0, last=2 so requester 0 wins first.
REQ-021 rst asserted mid-HOLD SHALL abort the hold with no gnt pulse; the first grant after deassertion follows REQ-012.

Structure
REQ-022 SHALL take BLANK_CHAR (6'b111110), BLANK_LINE (36'hFBEFBEFBE), NREQ=3 and state encodings from the shared display package, common to all display-path blocks.
REQ-023 SHALL place the round-robin winner selection in a combinational sub-module rr_arb3 (inputs req, last; outputs win index, any).

Verification (bench HOLD_CYCLES=4)
REQ-024 Assert rst -> data_out=36'hFBEFBEFBE, gnt=000, busy=0 immediately, before any clock edge.
REQ-025 req=010, msg1=36'h123456789 at edge 0 -> gnt=010 in cycle 1 only, data_out=36'h123456789 from cycle 1, busy=1 for cycles 1-4, busy=0 from cycle 5, data_out retained.
REQ-026 req=111 held after reset -> gnt sequence 001,010,100,001 at cycles 1,5,9,13; data_out tracks msg0,msg1,msg2,msg0.
REQ-027 msg0 changed during requester 0 hold -> data_out unchanged until the next grant edge.
REQ-028 clr at cycle 2 of a hold with req=100 pending -> data_out blank at cycle 3, gnt=100 at cycle 4.
REQ-029 rst pulse at cycle 2 of a hold -> blank line and busy=0 asynchronously; after release with req=001, gnt=001 one cycle after the first edge.
